// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and supervision: holds the PLL in reset, filters its lock signal,
// staggers the output-clock enables and retries a bounded number of times on lock loss.
module pll_lock_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_CYCLES    = 64,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3,
  localparam int RC_W          = $clog2(MAX_RETRIES + 2)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              pll_lock_raw,
  output logic              pll_resetn,
  output logic [NUM_CH-1:0] clkout_en,
  output logic              locked,
  output logic              lock_lost,
  output logic              fail,
  output logic [RC_W-1:0]   retry_count
);

  localparam int CNT_W = $clog2(RESET_CYCLES);
  localparam int T_W   = $clog2(LOCK_TIMEOUT);
  localparam int F_W   = $clog2(LOCK_CYCLES + 1);
  localparam int S_W   = $clog2(STAGGER_CYCLES + 1);
  localparam int I_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(LOCK_TIMEOUT - 1);
  localparam logic [F_W-1:0]   F_LAST   = F_W'(LOCK_CYCLES - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(STAGGER_CYCLES - 1);
  localparam logic [I_W-1:0]   I_LAST   = I_W'(NUM_CH - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_FILTER,
    S_ENABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t            state, state_next;
  logic              lock_meta, lock_s;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [T_W-1:0]    tcnt, tcnt_next;
  logic [F_W-1:0]    fcnt, fcnt_next;
  logic [S_W-1:0]    scnt, scnt_next;
  logic [I_W-1:0]    idx, idx_next;
  logic [RC_W-1:0]   rc_next;
  logic              attempt_failed;

  logic              rstn_d;
  logic [NUM_CH-1:0] en_d;
  logic              locked_d;
  logic              lost_d;
  logic              fail_d;

  // All state, counters and outputs are registered here; the lock input is
  // double-flopped because it is asynchronous to clkin.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= S_IDLE;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      cnt         <= '0;
      tcnt        <= '0;
      fcnt        <= '0;
      scnt        <= '0;
      idx         <= '0;
      retry_count <= '0;
      pll_resetn  <= 1'b0;
      clkout_en   <= '0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_next;
      lock_meta   <= pll_lock_raw;
      lock_s      <= lock_meta;
      cnt         <= cnt_next;
      tcnt        <= tcnt_next;
      fcnt        <= fcnt_next;
      scnt        <= scnt_next;
      idx         <= idx_next;
      retry_count <= rc_next;
      pll_resetn  <= rstn_d;
      clkout_en   <= en_d;
      locked      <= locked_d;
      lock_lost   <= lost_d;
      fail        <= fail_d;
    end
  end

  // Sequencing decisions. Dropping enable overrides everything; a timeout is
  // checked before any lock-based progress, and any failed attempt is routed
  // through the shared retry bookkeeping at the bottom.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    tcnt_next      = tcnt;
    fcnt_next      = fcnt;
    scnt_next      = scnt;
    idx_next       = idx;
    rc_next        = retry_count;
    attempt_failed = 1'b0;

    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_PLL_RST;
          cnt_next   = '0;
        end
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_next = S_WAIT_LOCK;
            tcnt_next  = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          tcnt_next = tcnt + 1'b1;
          if (tcnt == T_LAST) begin
            attempt_failed = 1'b1;
          end else if (lock_s) begin
            state_next = S_FILTER;
            fcnt_next  = F_W'(1);
          end
        end
        S_FILTER: begin
          tcnt_next = tcnt + 1'b1;
          if (tcnt == T_LAST) begin
            attempt_failed = 1'b1;
          end else if (!lock_s) begin
            state_next = S_WAIT_LOCK;
            fcnt_next  = '0;
          end else if (fcnt >= F_LAST) begin
            state_next = S_ENABLE;
            idx_next   = '0;
            scnt_next  = '0;
          end else begin
            fcnt_next = fcnt + 1'b1;
          end
        end
        S_ENABLE: begin
          if (!lock_s) begin
            attempt_failed = 1'b1;
          end else if (scnt == S_LAST) begin
            scnt_next = '0;
            if (idx == I_LAST) begin
              state_next = S_RUN;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            scnt_next = scnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            attempt_failed = 1'b1;
          end
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      if (attempt_failed) begin
        if (retry_count == RC_MAX) begin
          state_next = S_FAIL;
          rc_next    = RC_MAX + 1'b1;
        end else begin
          state_next = S_PLL_RST;
          cnt_next   = '0;
          rc_next    = retry_count + 1'b1;
        end
      end
    end

    if (state_next == S_IDLE) begin
      rc_next = '0;
    end
  end

  // Outputs are derived from the state being entered so that each registered
  // output lines up with that state; channel i rises on entry to its stagger slot.
  always_comb begin
    rstn_d   = 1'b0;
    en_d     = '0;
    locked_d = 1'b0;
    fail_d   = 1'b0;

    case (state_next)
      S_WAIT_LOCK, S_FILTER: begin
        rstn_d = 1'b1;
      end
      S_ENABLE: begin
        rstn_d = 1'b1;
        if (state == S_ENABLE) begin
          en_d = clkout_en;
        end
        if (scnt_next == '0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx_next == I_W'(i)) begin
              en_d[i] = ch_req[i];
            end
          end
        end
      end
      S_RUN: begin
        rstn_d   = 1'b1;
        locked_d = 1'b1;
        en_d     = ch_req;
      end
      S_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        rstn_d = 1'b0;
      end
    endcase

    lost_d = enable && !lock_s &&
             (state == S_FILTER || state == S_ENABLE || state == S_RUN);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised bench for pll_lock_sequencer, compared every cycle against a
// phase/age reference model, plus a few directed latency checks.
module tb_pll_lock_sequencer;

  localparam int NUM_CH         = 4;
  localparam int RESET_CYCLES   = 4;
  localparam int LOCK_CYCLES    = 8;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int STAGGER_CYCLES = 3;
  localparam int MAX_RETRIES    = 2;
  localparam int RC_W           = $clog2(MAX_RETRIES + 2);

  localparam int PH_IDLE    = 0;
  localparam int PH_RESET   = 1;
  localparam int PH_WAIT    = 2;
  localparam int PH_FILTER  = 3;
  localparam int PH_STAGGER = 4;
  localparam int PH_RUN     = 5;
  localparam int PH_FAIL    = 6;

  logic              clkin = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] ch_req;
  logic              pll_lock_raw;
  logic              pll_resetn;
  logic [NUM_CH-1:0] clkout_en;
  logic              locked;
  logic              lock_lost;
  logic              fail;
  logic [RC_W-1:0]   retry_count;

  int test_count = 0;
  int fail_count = 0;

  // Reference model: a phase, the age within it, the age of the lock window,
  // the run of good lock samples and the number of failed attempts.
  int                m_phase = PH_IDLE;
  int                m_age = 0;
  int                m_window = 0;
  int                m_good = 0;
  int                m_retries = 0;
  bit                m_s1 = 0;
  bit                m_s2 = 0;
  bit                m_lost = 0;
  logic [NUM_CH-1:0] m_en = '0;

  pll_lock_sequencer #(
    .NUM_CH(NUM_CH),
    .RESET_CYCLES(RESET_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STAGGER_CYCLES(STAGGER_CYCLES),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .enable(enable),
    .ch_req(ch_req),
    .pll_lock_raw(pll_lock_raw),
    .pll_resetn(pll_resetn),
    .clkout_en(clkout_en),
    .locked(locked),
    .lock_lost(lock_lost),
    .fail(fail),
    .retry_count(retry_count)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelFailAttempt();
    if (m_retries == MAX_RETRIES) begin
      m_phase   = PH_FAIL;
      m_retries = MAX_RETRIES + 1;
    end else begin
      m_retries++;
      m_phase = PH_RESET;
      m_age   = 0;
    end
  endtask

  task automatic modelStep(input logic rst, input logic en,
                           input logic [NUM_CH-1:0] req, input logic raw);
    bit lock;
    if (rst) begin
      m_phase = PH_IDLE; m_age = 0; m_window = 0; m_good = 0; m_retries = 0;
      m_s1 = 0; m_s2 = 0; m_lost = 0; m_en = '0;
      return;
    end
    lock   = m_s2;
    m_s2   = m_s1;
    m_s1   = raw;
    m_lost = 0;
    if (!en) begin
      m_phase   = PH_IDLE;
      m_retries = 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          m_phase = PH_RESET;
          m_age   = 0;
        end
        PH_RESET: begin
          if (m_age == RESET_CYCLES - 1) begin
            m_phase  = PH_WAIT;
            m_window = 0;
          end else m_age++;
        end
        PH_WAIT: begin
          if (m_window == LOCK_TIMEOUT - 1) modelFailAttempt();
          else begin
            m_window++;
            if (lock) begin
              m_phase = PH_FILTER;
              m_good  = 1;
            end
          end
        end
        PH_FILTER: begin
          m_lost = !lock;
          if (m_window == LOCK_TIMEOUT - 1) modelFailAttempt();
          else begin
            m_window++;
            if (!lock) begin
              m_phase = PH_WAIT;
              m_good  = 0;
            end else if (m_good + 1 >= LOCK_CYCLES) begin
              m_phase = PH_STAGGER;
              m_age   = 0;
              m_en    = req & NUM_CH'(1);
            end else m_good++;
          end
        end
        PH_STAGGER: begin
          m_lost = !lock;
          if (!lock) modelFailAttempt();
          else if (m_age == NUM_CH * STAGGER_CYCLES - 1) m_phase = PH_RUN;
          else begin
            m_age++;
            if (m_age % STAGGER_CYCLES == 0)
              m_en = m_en | (req & (NUM_CH'(1) << (m_age / STAGGER_CYCLES)));
          end
        end
        PH_RUN: begin
          m_lost = !lock;
          if (!lock) modelFailAttempt();
        end
        default: ;
      endcase
    end
    if (m_phase == PH_RUN) m_en = req;
    else if (m_phase != PH_STAGGER) m_en = '0;
  endtask

  task automatic checkAll();
    bit exp_rstn;
    exp_rstn = (m_phase == PH_WAIT || m_phase == PH_FILTER ||
                m_phase == PH_STAGGER || m_phase == PH_RUN);
    checkOutput("pll_resetn", 32'(pll_resetn), 32'(exp_rstn));
    checkOutput("clkout_en", 32'(clkout_en), 32'(m_en));
    checkOutput("locked", 32'(locked), 32'(m_phase == PH_RUN));
    checkOutput("lock_lost", 32'(lock_lost), 32'(m_lost));
    checkOutput("fail", 32'(fail), 32'(m_phase == PH_FAIL));
    checkOutput("retry_count", 32'(retry_count), 32'(m_retries));
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [NUM_CH-1:0] req, input logic raw);
    reset        = rst;
    enable       = en;
    ch_req       = req;
    pll_lock_raw = raw;
    modelStep(rst, en, req, raw);
    @(posedge clkin);
    @(negedge clkin);
    checkAll();
  endtask

  initial begin
    int low_count;
    bit seen_high;
    int t_bit0, t_bit3, t_locked, n;
    int drop_latency;
    int lost_seen;
    bit glitch_done, reached;
    int lock_hold, off_left;
    logic raw_val, rst_bit;
    logic [NUM_CH-1:0] req;

    reset = 1'b1; enable = 1'b1; ch_req = '1; pll_lock_raw = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1);

    // Bring-up with steady lock: reset width, stagger spacing, locked latency.
    low_count = 0; seen_high = 0;
    t_bit0 = -1; t_bit3 = -1; t_locked = -1;
    n = 0;
    while (t_locked < 0 && n < 100) begin
      n++;
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
      if (!seen_high) begin
        if (pll_resetn === 1'b0) low_count++;
        else seen_high = 1;
      end
      if (t_bit0 < 0 && clkout_en[0] === 1'b1) t_bit0 = n;
      if (t_bit3 < 0 && clkout_en[3] === 1'b1) t_bit3 = n;
      if (locked === 1'b1) t_locked = n;
    end
    checkOutput("resetn_low_cycles", 32'(low_count), 32'(RESET_CYCLES));
    checkOutput("bringup_locked", 32'(locked), 32'd1);
    checkOutput("stagger_span", 32'(t_bit3 - t_bit0), 32'(3 * STAGGER_CYCLES));
    checkOutput("locked_after_bit3", 32'(t_locked - t_bit3), 32'(STAGGER_CYCLES));

    applyStimulus(1'b0, 1'b1, 4'b0101, 1'b1);
    checkOutput("run_req_follow", 32'(clkout_en), 32'h5);
    applyStimulus(1'b0, 1'b1, 4'b1010, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);

    // Lock loss in RUN, then lock stays away until FAIL.
    drop_latency = 0;
    while (locked === 1'b1 && drop_latency < 10) begin
      drop_latency++;
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    end
    checkOutput("loss_latency", 32'(drop_latency), 32'd3);
    n = 0;
    while (fail !== 1'b1 && n < 400) begin
      n++;
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    end
    checkOutput("fail_reached", 32'(fail), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1111, 1'b0);

    // Restart with one lock glitch in FILTER, then drop enable mid-stagger.
    lost_seen = 0; glitch_done = 0; reached = 0; n = 0;
    while (!reached && n < 200) begin
      n++;
      raw_val = 1'b1;
      if (!glitch_done && m_phase == PH_FILTER && m_good == 3) begin
        raw_val = 1'b0;
        glitch_done = 1;
      end
      applyStimulus(1'b0, 1'b1, NUM_CH'($urandom), raw_val);
      if (lock_lost === 1'b1) lost_seen++;
      reached = (m_phase == PH_STAGGER && m_age == 4);
    end
    checkOutput("reach_enable", 32'(reached), 32'd1);
    checkOutput("filter_glitch_pulses", 32'(lost_seen), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);

    // Random soak: lock runs and dropouts, enable drops, occasional reset.
    lock_hold = 0; off_left = 0; req = 4'b1111; raw_val = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (lock_hold == 0) begin
        raw_val = ($urandom_range(0, 9) < 7);
        if (raw_val) lock_hold = int'($urandom_range(1, 150));
        else if ($urandom_range(0, 3) == 0) lock_hold = int'($urandom_range(40, 90));
        else lock_hold = int'($urandom_range(1, 4));
      end
      lock_hold--;
      if (off_left > 0) off_left--;
      else if ($urandom_range(0, 299) == 0) off_left = int'($urandom_range(1, 5));
      rst_bit = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 15) == 0) req = NUM_CH'($urandom);
      applyStimulus(rst_bit, off_left == 0, req, raw_val);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
